// File: rtl/cdc_handshake_rx.sv
// Receive side of the four-phase req/ack clock-crossing link: synchronizes req_i,
// captures data_i into a small FWFT FIFO and acknowledges only once the word is queued.
module cdc_handshake_rx #(
  parameter int unsigned pDATA_WIDTH  = 8,
  parameter int unsigned pSYNC_STAGES = 2,
  parameter int unsigned pDEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic                         req_i,
  input  logic [pDATA_WIDTH-1:0]       data_i,
  output logic                         ack_o,
  output logic                         out_valid,
  output logic [pDATA_WIDTH-1:0]       out_data,
  input  logic                         out_ready,
  output logic [$clog2(pDEPTH+1)-1:0]  level_o
);

  localparam int unsigned PtrW = $clog2(pDEPTH);
  localparam int unsigned LvlW = $clog2(pDEPTH + 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  (* ASYNC_REG = "TRUE" *) logic [pSYNC_STAGES-1:0] sync_q;
  logic req_s;

  state_e state_q, state_d;
  logic   capture;

  logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]        level_q, level_d;
  logic [pDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                   full, pop;

  // req synchronizer
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[pSYNC_STAGES-2:0], req_i};
    end
  end

  assign req_s = sync_q[pSYNC_STAGES-1];
  assign full  = (level_q == LvlW'(pDEPTH));

  // FSM state register
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; fullness is the registered level, so a same-cycle pop never unblocks
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_s) state_d = full ? StWait : StAck;
      StWait: begin
        if (!req_s) begin
          state_d = StIdle;
        end else if (!full) begin
          state_d = StAck;
        end
      end
      StAck:  if (!req_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    ack_o   = (state_q == StAck);
    capture = req_s && !full && ((state_q == StIdle) || (state_q == StWait));
  end

  assign pop      = out_valid && out_ready;
  assign rd_ptr_d = rd_ptr_q + PtrW'(pop);
  assign level_d  = level_q + LvlW'(capture) - LvlW'(pop);

  // Registered head: next head is either an existing entry or the word being pushed now
  always_comb begin
    out_data_d = out_data_q;
    if ((capture || pop) && (level_d != '0)) begin
      if (capture && (rd_ptr_d == wr_ptr_q)) begin
        out_data_d = data_i;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
    end else begin
      if (capture) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage needs no reset; out_data is held in its own reset flop
  always_ff @(posedge clk) begin
    if (capture) mem_q[wr_ptr_q] <= data_i;
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_data_q;
  assign level_o   = level_q;

endmodule
